// File: rtl/fpu_scoreboard_if.sv
// rtl/fpu_scoreboard_if.sv - operand/result/status bundle between an FPU under check and its scoreboard
interface fpu_scoreboard_if #(
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic [31:0]      A;
    logic [31:0]      B;
    logic             out_valid;
    logic [31:0]      result;
    logic             mismatch;
    logic             fail;
    logic [CNT_W-1:0] err_count;
    logic [CNT_W-1:0] check_count;
    real              first_exp;
    logic [31:0]      first_got;

    modport master (
        output in_valid, A, B, out_valid, result,
        input  mismatch, fail, err_count, check_count, first_exp, first_got
    );

    modport slave (
        input  in_valid, A, B, out_valid, result,
        output mismatch, fail, err_count, check_count, first_exp, first_got
    );
endinterface

// File: rtl/fpu_scoreboard.sv
// rtl/fpu_scoreboard.sv - real-valued reference checker for a pipelined single-precision FPU
// Expected results ride a LATENCY-deep queue; the head is judged against the DUT output each edge.
module fpu_scoreboard #(
    parameter string OP      = "ADD",
    parameter int    LATENCY = 1,
    parameter real   REL_TOL = 0.0,
    parameter int    CNT_W   = 16,
    parameter int    VERBOSE = 1
) (
    input  logic            clk,
    input  logic            rst,
    fpu_scoreboard_if.slave sb
);

    typedef enum logic [2:0] {
        OC_IDLE,
        OC_PASS,
        OC_WRONG,
        OC_MISSING,
        OC_SPURIOUS
    } outcome_e;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Subnormals are scaled directly; normals, Inf and NaN are re-packed into a double.
    function automatic real ftor(input logic [31:0] f);
        logic [10:0] exp_d;
        real         mag;
        if (f[30:23] == 8'd0) begin
            mag = real'(f[22:0]) * 1.401298464324817e-45;
            return f[31] ? -mag : mag;
        end
        exp_d = (f[30:23] == 8'hFF) ? 11'h7FF : ({3'b000, f[30:23]} + 11'd896);
        return $bitstoreal({f[31], exp_d, f[22:0], 29'd0});
    endfunction

    function automatic logic within_tol(input real got, input real exp);
        real diff;
        real lim;
        if ((got != got) || (exp != exp))
            return (got != got) && (exp != exp);
        if (got == exp)
            return 1'b1;
        if (((got - got) != 0.0) || ((exp - exp) != 0.0))
            return 1'b0;
        diff = (got > exp) ? (got - exp) : (exp - got);
        lim  = REL_TOL * ((exp < 0.0) ? -exp : exp);
        return diff <= lim;
    endfunction

    logic             valid_q [LATENCY];
    logic             valid_d [LATENCY];
    real              exp_q   [LATENCY];
    real              exp_d   [LATENCY];
    logic             mismatch_q, mismatch_d;
    logic             fail_q, fail_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;
    logic [CNT_W-1:0] check_count_q, check_count_d;
    real              first_exp_q, first_exp_d;
    logic [31:0]      first_got_q, first_got_d;

    real      a_r, b_r, op_r, got_r, head_exp, cap_exp;
    logic     head_valid, is_err;
    outcome_e outcome;

    always_comb begin
        a_r        = ftor(sb.A);
        b_r        = ftor(sb.B);
        got_r      = ftor(sb.result);
        head_valid = valid_q[LATENCY-1];
        head_exp   = exp_q[LATENCY-1];

        if (OP == "SUB")
            op_r = a_r - b_r;
        else if (OP == "MUL")
            op_r = a_r * b_r;
        else
            op_r = a_r + b_r;

        valid_d[0] = sb.in_valid;
        exp_d[0]   = sb.in_valid ? op_r : 0.0;
        for (int i = 1; i < LATENCY; i++) begin
            valid_d[i] = valid_q[i-1];
            exp_d[i]   = exp_q[i-1];
        end

        outcome = OC_IDLE;
        if (head_valid && sb.out_valid)
            outcome = within_tol(got_r, head_exp) ? OC_PASS : OC_WRONG;
        else if (head_valid)
            outcome = OC_MISSING;
        else if (sb.out_valid)
            outcome = OC_SPURIOUS;

        is_err  = outcome inside {OC_WRONG, OC_MISSING, OC_SPURIOUS};
        cap_exp = (outcome == OC_SPURIOUS) ? 0.0 : head_exp;

        mismatch_d    = is_err;
        fail_d        = fail_q | is_err;
        err_count_d   = err_count_q;
        check_count_d = check_count_q;
        if (is_err && (err_count_q != '1))
            err_count_d = err_count_q + CNT_ONE;
        if ((outcome == OC_PASS) && (check_count_q != '1))
            check_count_d = check_count_q + CNT_ONE;

        first_exp_d = first_exp_q;
        first_got_d = first_got_q;
        if (is_err && !fail_q) begin
            first_exp_d = cap_exp;
            first_got_d = (outcome == OC_MISSING) ? 32'd0 : sb.result;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                valid_q[i] <= 1'b0;
                exp_q[i]   <= 0.0;
            end
            mismatch_q    <= 1'b0;
            fail_q        <= 1'b0;
            err_count_q   <= '0;
            check_count_q <= '0;
            first_exp_q   <= 0.0;
            first_got_q   <= 32'd0;
        end else begin
            valid_q       <= valid_d;
            exp_q         <= exp_d;
            mismatch_q    <= mismatch_d;
            fail_q        <= fail_d;
            err_count_q   <= err_count_d;
            check_count_q <= check_count_d;
            first_exp_q   <= first_exp_d;
            first_got_q   <= first_got_d;
            if ((VERBOSE != 0) && is_err)
                $display("fpu_scoreboard %m: %s exp=%g got=%g (0x%08h) t=%0t",
                         outcome.name(), cap_exp, got_r, sb.result, $time);
        end
    end

    assign sb.mismatch    = mismatch_q;
    assign sb.fail        = fail_q;
    assign sb.err_count   = err_count_q;
    assign sb.check_count = check_count_q;
    assign sb.first_exp   = first_exp_q;
    assign sb.first_got   = first_got_q;

endmodule

// File: tb/tb_fpu_scoreboard.sv
// tb/tb_fpu_scoreboard.sv - directed table checks of fpu_scoreboard in ADD, MUL and saturating SUB setups
module tb_fpu_scoreboard;

    localparam logic [31:0] F_0     = 32'h0000_0000;
    localparam logic [31:0] F_0P25  = 32'h3E80_0000;
    localparam logic [31:0] F_0P5   = 32'h3F00_0000;
    localparam logic [31:0] F_M0P5  = 32'hBF00_0000;
    localparam logic [31:0] F_1     = 32'h3F80_0000;
    localparam logic [31:0] F_M1    = 32'hBF80_0000;
    localparam logic [31:0] F_1P5   = 32'h3FC0_0000;
    localparam logic [31:0] F_2     = 32'h4000_0000;
    localparam logic [31:0] F_2P25  = 32'h4010_0000;
    localparam logic [31:0] F_3     = 32'h4040_0000;
    localparam logic [31:0] F_3P5   = 32'h4060_0000;
    localparam logic [31:0] F_3P75  = 32'h4070_0000;
    localparam logic [31:0] F_4     = 32'h4080_0000;
    localparam logic [31:0] F_6     = 32'h40C0_0000;
    localparam logic [31:0] F_6P003 = 32'h40C0_1893;
    localparam logic [31:0] F_6P01  = 32'h40C0_51EC;
    localparam logic [31:0] F_7     = 32'h40E0_0000;

    localparam int S_ADD = 0;
    localparam int S_MUL = 1;
    localparam int S_SAT = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    fpu_scoreboard_if #(.CNT_W(16)) add_if ();
    fpu_scoreboard_if #(.CNT_W(16)) mul_if ();
    fpu_scoreboard_if #(.CNT_W(2))  sat_if ();

    fpu_scoreboard #(.OP("ADD"), .LATENCY(3), .REL_TOL(0.0), .CNT_W(16), .VERBOSE(0))
        u_add (.clk(clk), .rst(rst), .sb(add_if));
    fpu_scoreboard #(.OP("MUL"), .LATENCY(2), .REL_TOL(1.0e-3), .CNT_W(16), .VERBOSE(0))
        u_mul (.clk(clk), .rst(rst), .sb(mul_if));
    fpu_scoreboard #(.OP("SUB"), .LATENCY(1), .REL_TOL(0.0), .CNT_W(2), .VERBOSE(0))
        u_sat (.clk(clk), .rst(rst), .sb(sat_if));

    typedef struct {
        int          sel;
        logic        iv;
        logic [31:0] a;
        logic [31:0] b;
        logic        ov;
        logic [31:0] res;
        int          exp_chk;
        int          exp_err;
        logic        exp_mm;
        logic        exp_fail;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input int sel, input logic iv, input logic [31:0] a,
                                input logic [31:0] b, input logic ov, input logic [31:0] res,
                                input int ec, input int ee, input logic em, input logic ef);
        vec_t v;
        v.sel = sel; v.iv = iv; v.a = a; v.b = b; v.ov = ov; v.res = res;
        v.exp_chk = ec; v.exp_err = ee; v.exp_mm = em; v.exp_fail = ef;
        return v;
    endfunction

    task automatic chk_int(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic chk_hex(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic chk_real(input string name, input real got, input real exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %g expected %g", name, got, exp);
        end
    endtask

    task automatic drive(input int sel, input logic iv, input logic [31:0] a, input logic [31:0] b,
                         input logic ov, input logic [31:0] res);
        add_if.in_valid = 1'b0; add_if.A = F_0; add_if.B = F_0; add_if.out_valid = 1'b0; add_if.result = F_0;
        mul_if.in_valid = 1'b0; mul_if.A = F_0; mul_if.B = F_0; mul_if.out_valid = 1'b0; mul_if.result = F_0;
        sat_if.in_valid = 1'b0; sat_if.A = F_0; sat_if.B = F_0; sat_if.out_valid = 1'b0; sat_if.result = F_0;
        case (sel)
            S_ADD: begin add_if.in_valid = iv; add_if.A = a; add_if.B = b; add_if.out_valid = ov; add_if.result = res; end
            S_MUL: begin mul_if.in_valid = iv; mul_if.A = a; mul_if.B = b; mul_if.out_valid = ov; mul_if.result = res; end
            S_SAT: begin sat_if.in_valid = iv; sat_if.A = a; sat_if.B = b; sat_if.out_valid = ov; sat_if.result = res; end
            default: ;
        endcase
    endtask

    task automatic step(input int sel, input logic iv, input logic [31:0] a, input logic [31:0] b,
                        input logic ov, input logic [31:0] res);
        drive(sel, iv, a, b, ov, res);
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input int sel, input int ec, input int ee,
                               input logic em, input logic ef);
        int c, e;
        logic m, f;
        case (sel)
            S_ADD:   begin c = int'(add_if.check_count); e = int'(add_if.err_count); m = add_if.mismatch; f = add_if.fail; end
            S_MUL:   begin c = int'(mul_if.check_count); e = int'(mul_if.err_count); m = mul_if.mismatch; f = mul_if.fail; end
            default: begin c = int'(sat_if.check_count); e = int'(sat_if.err_count); m = sat_if.mismatch; f = sat_if.fail; end
        endcase
        chk_int({tag, ".check_count"}, c, ec);
        chk_int({tag, ".err_count"}, e, ee);
        chk_int({tag, ".mismatch"}, int'(m), int'(em));
        chk_int({tag, ".fail"}, int'(f), int'(ef));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        drive(S_ADD, 1'b0, F_0, F_0, 1'b0, F_0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        // ADD, latency 3: exact hit, then a wrong result against the same operands
        vt.push_back(mk(S_ADD, 1, F_1P5, F_2P25, 0, F_0,    0, 0, 0, 0));
        vt.push_back(mk(S_ADD, 0, F_0,   F_0,    0, F_0,    0, 0, 0, 0));
        vt.push_back(mk(S_ADD, 0, F_0,   F_0,    0, F_0,    0, 0, 0, 0));
        vt.push_back(mk(S_ADD, 0, F_0,   F_0,    1, F_3P75, 1, 0, 0, 0));
        vt.push_back(mk(S_ADD, 0, F_0,   F_0,    0, F_0,    1, 0, 0, 0));
        vt.push_back(mk(S_ADD, 1, F_1P5, F_2P25, 0, F_0,    1, 0, 0, 0));
        vt.push_back(mk(S_ADD, 0, F_0,   F_0,    0, F_0,    1, 0, 0, 0));
        vt.push_back(mk(S_ADD, 0, F_0,   F_0,    0, F_0,    1, 0, 0, 0));
        vt.push_back(mk(S_ADD, 0, F_0,   F_0,    1, F_3P5,  1, 1, 1, 1));
        vt.push_back(mk(S_ADD, 0, F_0,   F_0,    0, F_0,    1, 1, 0, 1));
        // MUL, latency 2: four back-to-back pairs, then an unmatched result
        vt.push_back(mk(S_MUL, 1, F_2,  F_3,    0, F_0,    0, 0, 0, 0));
        vt.push_back(mk(S_MUL, 1, F_M1, F_0P5,  0, F_0,    0, 0, 0, 0));
        vt.push_back(mk(S_MUL, 1, F_4,  F_0P25, 1, F_6,    1, 0, 0, 0));
        vt.push_back(mk(S_MUL, 1, F_0,  F_7,    1, F_M0P5, 2, 0, 0, 0));
        vt.push_back(mk(S_MUL, 0, F_0,  F_0,    1, F_1,    3, 0, 0, 0));
        vt.push_back(mk(S_MUL, 0, F_0,  F_0,    1, F_0,    4, 0, 0, 0));
        vt.push_back(mk(S_MUL, 0, F_0,  F_0,    1, F_1,    4, 1, 1, 1));
        vt.push_back(mk(S_MUL, 0, F_0,  F_0,    0, F_0,    4, 1, 0, 1));
        // SUB, latency 1, 2-bit counters: one pass then five wrong results in a row
        vt.push_back(mk(S_SAT, 1, F_1, F_0P5, 0, F_0,   0, 0, 0, 0));
        vt.push_back(mk(S_SAT, 1, F_1, F_0P5, 1, F_0P5, 1, 0, 0, 0));
        vt.push_back(mk(S_SAT, 1, F_1, F_0P5, 1, F_0,   1, 1, 1, 1));
        vt.push_back(mk(S_SAT, 1, F_1, F_0P5, 1, F_0,   1, 2, 1, 1));
        vt.push_back(mk(S_SAT, 1, F_1, F_0P5, 1, F_0,   1, 3, 1, 1));
        vt.push_back(mk(S_SAT, 1, F_1, F_0P5, 1, F_0,   1, 3, 1, 1));
        vt.push_back(mk(S_SAT, 0, F_0, F_0,   1, F_0,   1, 3, 1, 1));
        vt.push_back(mk(S_SAT, 0, F_0, F_0,   0, F_0,   1, 3, 0, 1));

        drive(S_ADD, 1'b0, F_0, F_0, 1'b0, F_0);
        repeat (2) @(posedge clk);
        #1;
        check_state("reset.add", S_ADD, 0, 0, 0, 0);
        chk_real("reset.first_exp", add_if.first_exp, 0.0);
        chk_hex("reset.first_got", add_if.first_got, F_0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < vt.size(); i++) begin
            step(vt[i].sel, vt[i].iv, vt[i].a, vt[i].b, vt[i].ov, vt[i].res);
            check_state($sformatf("vec%0d", i), vt[i].sel, vt[i].exp_chk, vt[i].exp_err,
                        vt[i].exp_mm, vt[i].exp_fail);
        end
        chk_real("add.first_exp", add_if.first_exp, 3.75);
        chk_hex("add.first_got", add_if.first_got, F_3P5);
        chk_real("mul.first_exp", mul_if.first_exp, 0.0);
        chk_hex("mul.first_got", mul_if.first_got, F_1);
        chk_real("sat.first_exp", sat_if.first_exp, 0.5);
        chk_hex("sat.first_got", sat_if.first_got, F_0);

        // Reset with two MUL entries in flight; the late outputs must count as spurious
        step(S_MUL, 1, F_2, F_3, 0, F_0);
        step(S_MUL, 1, F_2, F_3, 0, F_0);
        drive(S_ADD, 1'b0, F_0, F_0, 1'b0, F_0);
        rst = 1'b0;
        #1;
        check_state("midrst.mul", S_MUL, 0, 0, 0, 0);
        check_state("midrst.add", S_ADD, 0, 0, 0, 0);
        chk_int("midrst.sat.err_count", int'(sat_if.err_count), 0);
        chk_real("midrst.first_exp", mul_if.first_exp, 0.0);
        chk_hex("midrst.first_got", mul_if.first_got, F_0);
        @(negedge clk);
        rst = 1'b1;
        step(S_MUL, 0, F_0, F_0, 1, F_6);
        check_state("stale1", S_MUL, 0, 1, 1, 1);
        step(S_MUL, 0, F_0, F_0, 1, F_6);
        check_state("stale2", S_MUL, 0, 2, 1, 1);
        step(S_MUL, 0, F_0, F_0, 0, F_0);
        check_state("stale_idle", S_MUL, 0, 2, 0, 1);

        // Relative tolerance 1e-3 around 6.0
        do_reset();
        step(S_MUL, 1, F_3, F_2, 0, F_0);
        step(S_MUL, 1, F_3, F_2, 0, F_0);
        step(S_MUL, 0, F_0, F_0, 1, F_6P003);
        check_state("tol_in", S_MUL, 1, 0, 0, 0);
        step(S_MUL, 0, F_0, F_0, 1, F_6P01);
        check_state("tol_out", S_MUL, 1, 1, 1, 1);
        chk_real("tol.first_exp", mul_if.first_exp, 6.0);
        chk_hex("tol.first_got", mul_if.first_got, F_6P01);

        // Missing result on ADD latency 3
        do_reset();
        step(S_ADD, 1, F_1P5, F_2P25, 0, F_0);
        step(S_ADD, 0, F_0, F_0, 0, F_0);
        step(S_ADD, 0, F_0, F_0, 0, F_0);
        check_state("miss_early", S_ADD, 0, 0, 0, 0);
        step(S_ADD, 0, F_0, F_0, 0, F_0);
        check_state("missing", S_ADD, 0, 1, 1, 1);
        chk_real("miss.first_exp", add_if.first_exp, 3.75);
        chk_hex("miss.first_got", add_if.first_got, F_0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fpu_scoreboard.md
Name: fpu_scoreboard

Overview:
Simulation-only, clocked checker for pipelined FPU instances (ADD, SUB, MUL). It computes the real-valued expected result of each accepted operand pair and delays it through a LATENCY-deep queue. It then compares it against the DUT output with a relative tolerance, tracking spurious, missing and wrong results. It binds beside any FPU instance in the filter datapath and reports pass/fail status and counters to the bench.

Parameters:
OP, ADD, FPU_opcode under check: ADD, SUB or MUL (SUB = A - B).
LATENCY, 1, DUT pipeline depth in cycles; legal range 1..16.
REL_TOL, 0.0, real; allowed |got-exp| <= REL_TOL*|exp|; 0.0 demands exact equality.
CNT_W, 16, width of the saturating counters.
VERBOSE, 1, 1 = $display on each error; 0 = silent.

Ports:
clk  input  1  clock, all checks on posedge
rst  input  1  asynchronous reset, active-low
in_valid  input  1  operand pair A/B presented to the DUT this cycle
A  input  floatType  operand A
B  input  floatType  operand B
out_valid  input  1  DUT result valid this cycle
result  input  floatType  DUT result
mismatch  output  1  registered one-cycle pulse: an error was detected on the previous edge
fail  output  1  sticky: at least one error since reset
err_count  output  CNT_W  errors since reset, saturating
check_count  output  CNT_W  successful compares since reset, saturating
first_exp  output  real  expected value of the first error (0.0 if none)
first_got  output  floatType  DUT result of the first error (all zeros if none)

Behaviour:
- Reset: rst low asynchronously clears the queue valid bits, mismatch, fail, err_count, check_count, first_exp and first_got. No checks occur while rst is low.
- Reset mid-operation: in-flight entries are dropped. DUT outputs in the first LATENCY cycles after release are judged only against post-reset entries, so stale outputs count as spurious.
- Queue: LATENCY-stage shift register of {valid, exp(real)}. It advances every posedge. Stage 0 loads {in_valid, ftor(A) op ftor(B)}.
  - Head = entry loaded LATENCY edges earlier.
  - Operands sampled at edge t are checked against result at edge t+LATENCY.
- Per-edge classification, exactly one outcome:
  - head.valid & out_valid: if |ftor(result)-head.exp| <= REL_TOL*|head.exp| -> PASS, else WRONG.
  - head.valid & !out_valid -> MISSING.
  - !head.valid & out_valid -> SPURIOUS.
  - Neither valid -> IDLE, no action.
- PASS: check_count += 1.
- WRONG / MISSING / SPURIOUS:
  - err_count += 1; fail <= 1; mismatch pulses high on the following cycle.
  - If this is the first error since reset: capture first_exp (head.exp, or 0.0 for SPURIOUS) and first_got (result, or zeros for MISSING).
  - VERBOSE prints kind, exp, got and $time.
- At most one count increment per edge. Counters saturate at all-ones and do not wrap.
- mismatch reflects only the immediately preceding edge. Back-to-back errors hold it high continuously.
- in_valid and out_valid may be high on the same edge; the enqueue and the head check are independent.
- NaN/Inf: an exp or got that is NaN counts as WRONG unless both are NaN.

Test Plan:
- ADD, LATENCY=3: in_valid with A=1.5, B=2.25 at edge 0; result=3.75 with out_valid at edge 3 -> check_count=1, err_count=0, fail=0, mismatch never high.
- Same stimulus, result=3.5 -> mismatch high for one cycle after edge 3, err_count=1, fail=1, first_exp=3.75, first_got=3.5.
- MUL, LATENCY=2, 4 back-to-back pairs (2*3, -1*0.5, 4*0.25, 0*7) with correct results at edges 2..5 -> check_count=4; then out_valid at edge 6 with nothing queued -> SPURIOUS, err_count=1.
- LATENCY=3, in_valid at edge 0, out_valid held low at edge 3 -> MISSING: err_count=1, first_got=0.
- REL_TOL=1e-3, MUL 3.0*2.0, result=6.003 -> PASS; result=6.01 -> WRONG.
- Reset and saturation:
  - Pulse rst low with 2 entries in flight -> err_count, check_count, fail all 0; the DUT outputs arriving after release count as SPURIOUS.
  - CNT_W=2 with 5 wrong results -> err_count stays at 3.
